// File: rtl/capture_buffer_pkg.sv
// ============================================================================
// Module  : capture_buffer_pkg
// Purpose : Shared types, widths and sign-extension helper for capture_buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package capture_buffer_pkg;

  localparam int c_word_w = 32;
  localparam int c_half_w = 16;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  // Replicates bit w-1 of v into every bit position at or above w.
  function automatic logic [c_half_w-1:0] sext16(input logic [c_half_w-1:0] v, input int w);
    logic [c_half_w-1:0] r;
    r = v;
    for (int i = 0; i < c_half_w; i++) begin
      if (i >= w) r[i] = v[w-1];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/capture_buffer_sdp_bram.sv
// ============================================================================
// Module  : capture_buffer_sdp_bram
// Purpose : Simple dual-port RAM, one write port and one registered read port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module capture_buffer_sdp_bram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // No reset on the array or read register so the tools map this onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/capture_buffer.sv
// ============================================================================
// Module  : capture_buffer
// Purpose : Stores sample pairs into RAM, then streams them out over valid/ready.
// Revision: 1.0
// ============================================================================
`default_nettype none

module capture_buffer
  import capture_buffer_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [31:0]         wr_addr,
  input  logic [DATA_W-1:0]   din_A,
  input  logic [DATA_W-1:0]   din_B,
  input  logic                clear,
  input  logic                rd_start,
  output logic [31:0]         m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tlast,
  output logic [ADDR_W:0]     fill,
  output logic                busy,
  output logic                overflow,
  output logic                wr_blocked
);

  localparam logic [ADDR_W:0] c_one = {{ADDR_W{1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_W:0]       r_fill;
  logic [ADDR_W:0]       w_fill_nxt;
  logic [ADDR_W-1:0]     r_rd_ptr;
  logic                  r_overflow;
  logic                  r_wr_blocked;

  logic                  w_idle;
  logic                  w_present;
  logic                  w_addr_hi_bad;
  logic [ADDR_W-1:0]     w_idx;
  logic [ADDR_W:0]       w_idx_p1;
  logic                  w_wr_ok;
  logic                  w_last;
  logic                  w_ram_re;
  logic [c_word_w-1:0]   w_word;
  logic [c_word_w-1:0]   w_rdata;
  logic [1:0]            w_unused_addr_lsb;

  assign w_idle            = (r_state == S_IDLE);
  assign w_present         = (r_state == S_PRESENT);
  assign w_unused_addr_lsb = wr_addr[1:0];
  assign w_addr_hi_bad     = |wr_addr[31:ADDR_W+2];
  assign w_idx             = wr_addr[ADDR_W+1:2];
  assign w_idx_p1          = {1'b0, w_idx} + c_one;
  assign w_wr_ok           = wr_en & w_idle & ~clear & ~w_addr_hi_bad;
  assign w_fill_nxt        = (w_wr_ok && (w_idx_p1 > r_fill)) ? w_idx_p1 : r_fill;
  assign w_last            = ({1'b0, r_rd_ptr} == (r_fill - c_one));
  assign w_word            = {sext16(c_half_w'(din_A), DATA_W), sext16(c_half_w'(din_B), DATA_W)};

  capture_buffer_sdp_bram #(
    .ADDR_W (ADDR_W),
    .DATA_W (c_word_w)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_ok),
    .i_waddr (w_idx),
    .i_wdata (w_word),
    .i_re    (w_ram_re),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // The readout decision uses the post-write fill so a same-cycle write is included.
  always_comb begin
    w_state_nxt = r_state;
    w_ram_re    = 1'b0;
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    m_tdata     = '0;
    busy        = !w_idle;
    if (clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (rd_start && (w_fill_nxt != '0)) w_state_nxt = S_FETCH;
        end
        S_FETCH: begin
          w_ram_re    = 1'b1;
          w_state_nxt = S_PRESENT;
        end
        S_PRESENT: begin
          if (m_tready) w_state_nxt = w_last ? S_IDLE : S_FETCH;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
    // Read data only refreshes in FETCH, so it holds steady through a stall.
    if (w_present) begin
      m_tvalid = 1'b1;
      m_tlast  = w_last;
      m_tdata  = w_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill       <= '0;
      r_rd_ptr     <= '0;
      r_overflow   <= 1'b0;
      r_wr_blocked <= 1'b0;
    end else if (clear) begin
      r_fill       <= '0;
      r_rd_ptr     <= '0;
      r_overflow   <= 1'b0;
      r_wr_blocked <= 1'b0;
    end else begin
      r_fill <= w_fill_nxt;
      if (wr_en && w_idle && w_addr_hi_bad) r_overflow <= 1'b1;
      if (wr_en && !w_idle) r_wr_blocked <= 1'b1;
      if (w_idle && rd_start) r_rd_ptr <= '0;
      else if (w_present && m_tready && !w_last) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign fill       = r_fill;
  assign overflow   = r_overflow;
  assign wr_blocked = r_wr_blocked;

endmodule

`default_nettype wire

// File: tb/tb_capture_buffer.sv
// ============================================================================
// Module  : tb_capture_buffer
// Purpose : Directed and randomized checks of capture_buffer against a word-array model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_capture_buffer;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 14;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [31:0]       wr_addr;
  logic [DATA_W-1:0] din_A;
  logic [DATA_W-1:0] din_B;
  logic              clear;
  logic              rd_start;
  logic [31:0]       m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;
  logic [ADDR_W:0]   fill;
  logic              busy;
  logic              overflow;
  logic              wr_blocked;

  always #5 clk = ~clk;

  capture_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .din_A(din_A), .din_B(din_B),
    .clear(clear), .rd_start(rd_start), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast), .fill(fill), .busy(busy),
    .overflow(overflow), .wr_blocked(wr_blocked)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] mem_m [DEPTH];
  int          fill_m;
  bit          ovf_m;
  bit          blk_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack_word(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    sa = $signed(a);
    sb = $signed(b);
    return {sa, sb};
  endfunction

  task automatic model_clear();
    fill_m = 0;
    ovf_m  = 1'b0;
    blk_m  = 1'b0;
  endtask

  task automatic chk_status(input string tag, input bit exp_busy);
    chk({tag, "_fill"}, 32'(fill), 32'(fill_m));
    chk({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    chk({tag, "_ovf"},  32'(overflow), 32'(ovf_m));
    chk({tag, "_blk"},  32'(wr_blocked), 32'(blk_m));
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [DATA_W-1:0] a,
                          input logic [DATA_W-1:0] b, input bit with_rd);
    int idx;
    wr_en = 1'b1; wr_addr = addr; din_A = a; din_B = b; rd_start = with_rd;
    tick();
    wr_en = 1'b0; rd_start = 1'b0;
    if (addr[31:ADDR_W+2] != '0) begin
      ovf_m = 1'b1;
    end else begin
      idx = int'(addr[ADDR_W+1:2]);
      mem_m[idx] = pack_word(a, b);
      if (idx + 1 > fill_m) fill_m = idx + 1;
    end
    chk("wr_fill", 32'(fill), 32'(fill_m));
    chk("wr_ovf", 32'(overflow), 32'(ovf_m));
  endtask

  // mode 0: always ready, 1: ready toggles, 2: random ready; inj_iter drives a write while busy.
  task automatic readout(input int mode, input int inj_iter, input bit started);
    int          k;
    int          exp_n;
    bit          done;
    bit          stalled;
    logic [31:0] prev;
    k = 0; done = 1'b0; stalled = 1'b0; prev = '0;
    exp_n = fill_m;
    if (!started) begin
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
    end
    chk("rd_busy", 32'(busy), 32'(exp_n != 0));
    for (int c = 0; c < 4 * exp_n + 20 && !done; c++) begin
      case (mode)
        0:       m_tready = 1'b1;
        1:       m_tready = c[0];
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
      if (c == inj_iter) begin
        wr_en = 1'b1;
        wr_addr = {20'd0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
        din_A = DATA_W'($urandom); din_B = DATA_W'($urandom);
      end
      if (m_tvalid) begin
        chk("rd_data", m_tdata, mem_m[k]);
        chk("rd_last", 32'(m_tlast), 32'(k == exp_n - 1));
        if (stalled) chk("rd_stable", m_tdata, prev);
        prev = m_tdata;
        stalled = !m_tready;
        if (m_tready) begin
          k++;
          if (k == exp_n) done = 1'b1;
        end
      end
      tick();
      if (c == inj_iter) begin
        wr_en = 1'b0;
        blk_m = 1'b1;
      end
    end
    m_tready = 1'b0;
    chk("rd_count", 32'(k), 32'(exp_n));
    chk("rd_end_valid", 32'(m_tvalid), 32'd0);
    chk_status("rd_end", 1'b0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; din_A = '0; din_B = '0;
    clear = 1'b0; rd_start = 1'b0; m_tready = 1'b0;
    model_clear();
    tick(); tick();
    chk("rst_tdata", m_tdata, 32'd0);
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_tlast), 32'd0);
    chk_status("rst", 1'b0);
    rst = 1'b0;
    tick();
    chk_status("post_rst", 1'b0);

    // Four fixed sample pairs, extreme sign values.
    for (int i = 0; i < 4; i++) do_write(32'(i * 4), 14'h1FFF, 14'h2000, 1'b0);
    chk("t1_fill", 32'(fill), 32'd4);
    readout(0, -1, 1'b0);

    // Out-of-range address, then a valid write with nonzero low address bits.
    do_write(32'h0000_1000, 14'h0123, 14'h3210, 1'b0);
    chk("t2_ovf", 32'(overflow), 32'd1);
    do_write(32'h0000_0017, 14'h0ABC, 14'h3FFF, 1'b0);
    readout(1, -1, 1'b0);

    // Randomized capture with random consumer backpressure.
    clear = 1'b1; tick(); clear = 1'b0; model_clear();
    chk_status("clr", 1'b0);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0)
        do_write({20'($urandom_range(1, 32'hFFFFF)), 12'($urandom)}, DATA_W'($urandom), DATA_W'($urandom), 1'b0);
      else
        do_write({24'd0, 6'($urandom_range(0, 63)), 2'($urandom)}, DATA_W'($urandom), DATA_W'($urandom), 1'b0);
    end
    readout(2, -1, 1'b0);
    readout(1, 3, 1'b0);
    chk("blk_set", 32'(wr_blocked), 32'd1);

    // Clear during a stalled readout.
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    repeat (4) tick();
    chk("mid_valid", 32'(m_tvalid), 32'(fill_m != 0));
    clear = 1'b1; tick(); clear = 1'b0; model_clear();
    chk("clr_valid", 32'(m_tvalid), 32'd0);
    chk_status("clr_mid", 1'b0);

    // Readout request with an empty buffer is ignored.
    readout(0, -1, 1'b0);
    tick();
    chk("empty_busy", 32'(busy), 32'd0);

    // Clear wins over a same-cycle write, valid or out of range.
    clear = 1'b1; wr_en = 1'b1; wr_addr = 32'h0000_0008; tick();
    wr_addr = 32'h0000_1000; tick();
    clear = 1'b0; wr_en = 1'b0;
    chk_status("clr_wr", 1'b0);

    // Same-cycle write and readout request: the new word is included.
    do_write(32'h0, DATA_W'($urandom), DATA_W'($urandom), 1'b0);
    do_write(32'h4, DATA_W'($urandom), DATA_W'($urandom), 1'b0);
    do_write(32'h8, DATA_W'($urandom), DATA_W'($urandom), 1'b1);
    chk("wr_rd_fill", 32'(fill), 32'd3);
    readout(0, -1, 1'b1);

    // Completely full buffer, written from the top down.
    clear = 1'b1; tick(); clear = 1'b0; model_clear();
    for (int i = DEPTH - 1; i >= 0; i--) do_write(32'(i * 4), DATA_W'($urandom), DATA_W'($urandom), 1'b0);
    chk("full_fill", 32'(fill), 32'(DEPTH));
    readout(0, -1, 1'b0);

    // Asynchronous reset in the middle of a readout.
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    m_tready = 1'b1;
    repeat (6) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_tdata", m_tdata, 32'd0);
    chk("arst_tvalid", 32'(m_tvalid), 32'd0);
    chk("arst_tlast", 32'(m_tlast), 32'd0);
    model_clear();
    chk_status("arst", 1'b0);
    m_tready = 1'b0;
    tick();
    rst = 1'b0;
    tick(); tick();
    chk_status("arst_rel", 1'b0);
    chk("arst_rel_valid", 32'(m_tvalid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
